epcs_program_ctrl: RTL

Sequences remote reprogramming of the EPCS configuration flash. It acts on the erase request and the 256-byte data blocks that the UDP receive path pushes into the EPCS receive FIFO. It runs a bulk erase, then repeats a page-load, page-program and request-next-block loop until `num_blocks` pages are written, and it reports progress back to the send path. It sits between the UDP receive block, the EPCS receive FIFO, the send path (`send_more` handshake) and the flash serial engine.

---
 rtl/epcs_program_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/epcs_program_ctrl.sv
// -----------------------------------------------------------------------------
// epcs_program_ctrl
//
// Remote reprogramming sequencer for the EPCS configuration flash. It accepts
// an erase request and runs a bulk erase. It then loops over these steps:
//   - wait until a full 256-byte block sits in the EPCS receive FIFO;
//   - stream that block into the flash page buffer;
//   - start a page program and wait for the flash to finish;
//   - ask the send path for the next block.
// The loop stops after num_blocks pages.
//
// Optional feature: define EPCS_TIMEOUT_EN to add a TIMEOUT_W-bit watchdog.
// It covers the erase/page busy waits and the send_more handshake, and it
// raises prog_error when it overflows.
//
// Ports
//   rx_clock, reset          : clock, synchronous active-high reset
//   erase / erase_ACK        : erase request level / one-cycle accept pulse
//   num_blocks               : pages in the image (latched after erase)
//   EPCS_wrused/_rdreq/_data : receive FIFO (non-showahead, data 1 cycle late)
//   send_more/_ACK           : next-block request to the send path
//   flash_bulk_erase         : one-cycle bulk-erase start
//   flash_page_start         : one-cycle page-program start
//   flash_addr               : page byte address
//   flash_wdata/flash_wr     : page buffer write port
//   flash_busy               : flash engine busy
//   erase_done, program_done,
//   prog_error               : status levels
//   blocks_written           : pages programmed since the last erase
// -----------------------------------------------------------------------------
module epcs_program_ctrl #(
    parameter logic [23:0] START_ADDR = 24'h000000,
    parameter int          TIMEOUT_W  = 27
) (
    input  logic        rx_clock,
    input  logic        reset,
    input  logic        erase,
    output logic        erase_ACK,
    input  logic [31:0] num_blocks,
    input  logic [9:0]  EPCS_wrused,
    output logic        EPCS_rdreq,
    input  logic [7:0]  EPCS_data,
    output logic        send_more,
    input  logic        send_more_ACK,
    output logic        flash_bulk_erase,
    output logic        flash_page_start,
    output logic [23:0] flash_addr,
    output logic [7:0]  flash_wdata,
    output logic        flash_wr,
    input  logic        flash_busy,
    output logic        erase_done,
    output logic        program_done,
    output logic        prog_error,
    output logic [31:0] blocks_written
);

    typedef enum logic [3:0] {
        S_IDLE, S_ERASE, S_ERASE_WAIT, S_WAIT_DATA, S_LOAD,
        S_PAGE, S_PAGE_WAIT, S_REQ_MORE, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] blocks_q, blocks_d;
    logic [31:0] total_q, total_d;
    logic        latched_q, latched_d;   // total already captured since erase
    logic [23:0] addr_q, addr_d;
    logic        erase_done_q, erase_done_d;
    logic        prog_done_q, prog_done_d;
    logic        prog_err_q, prog_err_d;
    logic        ack_q, ack_d;
    logic        bulk_q, bulk_d;
    logic        page_start_q, page_start_d;
    logic        send_more_q, send_more_d;
    logic [8:0]  rd_cnt_q, rd_cnt_d;     // bit 8 set once 256 reads are issued
    logic        rd_valid_q, rd_valid_d; // FIFO data valid this cycle
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  wr_cnt_q, wr_cnt_d;
    logic [31:0] total_eff;
    logic        rdreq;

`ifdef EPCS_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 timed;
`endif

    assign rdreq     = (state_q == S_LOAD) && !rd_cnt_q[8];
    assign total_eff = latched_q ? total_q : num_blocks;

    always_comb begin
        state_d      = state_q;
        blocks_d     = blocks_q;
        total_d      = total_q;
        latched_d    = latched_q;
        addr_d       = addr_q;
        erase_done_d = erase_done_q;
        prog_done_d  = prog_done_q;
        prog_err_d   = prog_err_q;
        ack_d        = 1'b0;
        bulk_d       = 1'b0;
        page_start_d = 1'b0;
        send_more_d  = send_more_q;
        rd_cnt_d     = rd_cnt_q + {8'd0, rdreq};
        // Read pipeline: strobe -> data valid next cycle -> page buffer write.
        rd_valid_d   = rdreq;
        wr_d         = rd_valid_q;
        wdata_d      = rd_valid_q ? EPCS_data : wdata_q;
        wr_cnt_d     = wr_cnt_q + {7'd0, wr_q};

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (erase) begin
                    ack_d        = 1'b1;
                    bulk_d       = 1'b1;
                    blocks_d     = 32'd0;
                    erase_done_d = 1'b0;
                    prog_done_d  = 1'b0;
                    prog_err_d   = 1'b0;
                    addr_d       = START_ADDR;
                    latched_d    = 1'b0;
                    state_d      = S_ERASE;
                end
            end
            S_ERASE: begin
                if (flash_busy) state_d = S_ERASE_WAIT;
            end
            S_ERASE_WAIT: begin
                if (!flash_busy) begin
                    erase_done_d = 1'b1;
                    state_d      = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                rd_cnt_d  = 9'd0;
                wr_cnt_d  = 8'd0;
                total_d   = total_eff;
                latched_d = 1'b1;
                if (total_eff == 32'd0) begin
                    prog_err_d = 1'b1;
                    state_d    = S_ERROR;
                end else if (EPCS_wrused >= 10'd256) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // The 256th write is on the bus now. Start the page next cycle.
                if (wr_q && (wr_cnt_q == 8'hFF)) begin
                    page_start_d = 1'b1;
                    state_d      = S_PAGE;
                end
            end
            S_PAGE: begin
                if (flash_busy) state_d = S_PAGE_WAIT;
            end
            S_PAGE_WAIT: begin
                if (!flash_busy) begin
                    blocks_d = blocks_q + 32'd1;
                    addr_d   = addr_q + 24'h000100;
                    if ((blocks_q + 32'd1) == total_q) begin
                        prog_done_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        send_more_d = 1'b1;
                        state_d     = S_REQ_MORE;
                    end
                end
            end
            S_REQ_MORE: begin
                if (send_more_ACK) begin
                    send_more_d = 1'b0;
                    state_d     = S_WAIT_DATA;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef EPCS_TIMEOUT_EN
        timed = (state_q == S_ERASE) || (state_q == S_ERASE_WAIT) ||
                (state_q == S_PAGE)  || (state_q == S_PAGE_WAIT)  ||
                (state_q == S_REQ_MORE);
        // A real transition in the same cycle wins over the watchdog.
        if (timed && (state_d == state_q) && (&tmo_q)) begin
            prog_err_d  = 1'b1;
            send_more_d = 1'b0;
            state_d     = S_ERROR;
        end
        if (state_d != state_q) tmo_d = '0;
        else if (timed)         tmo_d = tmo_q + 1'b1;
        else                    tmo_d = '0;
`endif
    end

    always_ff @(posedge rx_clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            blocks_q     <= 32'd0;
            total_q      <= 32'd0;
            latched_q    <= 1'b0;
            addr_q       <= START_ADDR;
            erase_done_q <= 1'b0;
            prog_done_q  <= 1'b0;
            prog_err_q   <= 1'b0;
            ack_q        <= 1'b0;
            bulk_q       <= 1'b0;
            page_start_q <= 1'b0;
            send_more_q  <= 1'b0;
            rd_cnt_q     <= 9'd0;
            rd_valid_q   <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= 8'd0;
            wr_cnt_q     <= 8'd0;
`ifdef EPCS_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            blocks_q     <= blocks_d;
            total_q      <= total_d;
            latched_q    <= latched_d;
            addr_q       <= addr_d;
            erase_done_q <= erase_done_d;
            prog_done_q  <= prog_done_d;
            prog_err_q   <= prog_err_d;
            ack_q        <= ack_d;
            bulk_q       <= bulk_d;
            page_start_q <= page_start_d;
            send_more_q  <= send_more_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_valid_q   <= rd_valid_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            wr_cnt_q     <= wr_cnt_d;
`ifdef EPCS_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign erase_ACK        = ack_q;
    assign EPCS_rdreq       = rdreq;
    assign send_more        = send_more_q;
    assign flash_bulk_erase = bulk_q;
    assign flash_page_start = page_start_q;
    assign flash_addr       = addr_q;
    assign flash_wdata      = wdata_q;
    assign flash_wr         = wr_q;
    assign erase_done       = erase_done_q;
    assign program_done     = prog_done_q;
    assign prog_error       = prog_err_q;
    assign blocks_written   = blocks_q;

endmodule
